// File: rtl/exec_sequencer_pkg.sv
// Shared definitions for the execute sequencer: opcodes, FSM encoding,
// instruction field positions and the control-class helper.
package exec_sequencer_pkg;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_JMP = 4'b1101;
  localparam logic [3:0] OP_JZ  = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  // Instruction field bit positions within the 16-bit word
  localparam int OPC_MSB   = 15;
  localparam int OPC_LSB   = 12;
  localparam int AM_BIT    = 11;
  localparam int RD_MSB    = 10;
  localparam int RD_LSB    = 8;
  localparam int RS1_MSB   = 7;
  localparam int RS1_LSB   = 5;
  localparam int RS2_MSB   = 4;
  localparam int RS2_LSB   = 2;
  localparam int MADDR_MSB = 4;
  localparam int MADDR_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } seq_state_t;

  // Control-flow opcodes are resolved by the sequencer and never reach the ALU
  function automatic logic is_ctrl_op(input logic [3:0] op);
    return (op == OP_NOP) || (op == OP_JMP) || (op == OP_JZ) || (op == OP_HLT);
  endfunction

endpackage

// File: rtl/exec_sequencer_if.sv
// Instruction-memory and execute-unit bus of the sequencer.
// master = sequencer side, slave = memory/execute side.
interface exec_sequencer_if #(
  parameter int PC_W    = 5,
  parameter int INSTR_W = 16
);

  logic               imem_rd;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_data;

  logic               ex_enable;
  logic [3:0]         ex_opcode;
  logic               ex_am;
  logic [2:0]         ex_rd;
  logic [2:0]         ex_rs1;
  logic [2:0]         ex_rs2;
  logic [4:0]         ex_mem_addr;
  logic [PC_W-1:0]    ex_instr_mem_addr;
  logic               ex_zero_flag;

  modport master (
    output imem_rd, imem_addr,
    input  imem_data,
    output ex_enable, ex_opcode, ex_am, ex_rd, ex_rs1, ex_rs2,
    output ex_mem_addr, ex_instr_mem_addr,
    input  ex_zero_flag
  );

  modport slave (
    input  imem_rd, imem_addr,
    output imem_data,
    input  ex_enable, ex_opcode, ex_am, ex_rd, ex_rs1, ex_rs2,
    input  ex_mem_addr, ex_instr_mem_addr,
    output ex_zero_flag
  );

endinterface

// File: rtl/exec_sequencer_instr_decoder.sv
// Combinational split of the instruction register into execute-unit fields
// plus the control-class flag used by the sequencer FSM.
module exec_sequencer_instr_decoder
  import exec_sequencer_pkg::*;
#(
  parameter int INSTR_W = 16
) (
  input  logic [INSTR_W-1:0] ir,
  output logic [3:0]         opcode,
  output logic               am,
  output logic [2:0]         rd,
  output logic [2:0]         rs1,
  output logic [2:0]         rs2,
  output logic [4:0]         mem_addr,
  output logic               is_ctrl
);

  // Field extraction and opcode classification
  always_comb begin
    opcode   = ir[OPC_MSB:OPC_LSB];
    am       = ir[AM_BIT];
    rd       = ir[RD_MSB:RD_LSB];
    rs1      = ir[RS1_MSB:RS1_LSB];
    rs2      = ir[RS2_MSB:RS2_LSB];
    mem_addr = ir[MADDR_MSB:MADDR_LSB];
    is_ctrl  = is_ctrl_op(ir[OPC_MSB:OPC_LSB]);
  end

endmodule

// File: rtl/exec_sequencer.sv
// Fetch/decode/execute sequencer for the 8-bit core. Owns the program
// counter, instruction register and the zero flag seen by JZ.
//
//   state  | meaning
//   IDLE   | waiting for start after reset
//   FETCH  | imem read strobe at address pc
//   DECODE | IR captured from imem_data
//   EXEC   | ALU: ex_enable for EX_CYCLES cycles; control: pc update
//   WB     | latch zero flag, pc+1
//   HALT   | stopped by HLT, start restarts at RESET_PC
module exec_sequencer
  import exec_sequencer_pkg::*;
#(
  parameter int              PC_W      = 5,
  parameter int              INSTR_W   = 16,
  parameter int              EX_CYCLES = 1,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  exec_sequencer_if.master    bus,
  output logic [PC_W-1:0]     pc,
  output logic                busy,
  output logic                halted
);

  localparam logic [2:0] EX_LAST = 3'(EX_CYCLES - 1);

  seq_state_t         state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    instr_pc_q;
  logic [INSTR_W-1:0] ir_q;
  logic               zf_q, zf_d;
  logic [2:0]         ex_cnt_q, ex_cnt_d;
  logic               ir_load;
  logic               imem_rd_c;
  logic               ex_enable_c;

  logic [3:0]         dec_opcode;
  logic               dec_am;
  logic [2:0]         dec_rd, dec_rs1, dec_rs2;
  logic [4:0]         dec_mem_addr;
  logic               dec_is_ctrl;

  logic [PC_W-1:0]    pc_inc;
  logic [PC_W-1:0]    jmp_target;

  exec_sequencer_instr_decoder #(
    .INSTR_W (INSTR_W)
  ) u_dec (
    .ir       (ir_q),
    .opcode   (dec_opcode),
    .am       (dec_am),
    .rd       (dec_rd),
    .rs1      (dec_rs1),
    .rs2      (dec_rs2),
    .mem_addr (dec_mem_addr),
    .is_ctrl  (dec_is_ctrl)
  );

  assign pc_inc     = pc_q + PC_W'(1);
  assign jmp_target = PC_W'(dec_mem_addr);

  // State, pc, IR, flag and execute-cycle counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      instr_pc_q <= '0;
      zf_q       <= 1'b0;
      ex_cnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      zf_q     <= zf_d;
      ex_cnt_q <= ex_cnt_d;
      if (ir_load) begin
        ir_q       <= bus.imem_data;
        instr_pc_q <= pc_q;
      end
    end
  end

  // Next-state, pc/flag update and strobe generation
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    zf_d        = zf_q;
    ex_cnt_d    = ex_cnt_q;
    ir_load     = 1'b0;
    imem_rd_c   = 1'b0;
    ex_enable_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        imem_rd_c = 1'b1;
        state_d   = ST_DECODE;
      end
      ST_DECODE: begin
        ir_load  = 1'b1;
        ex_cnt_d = EX_LAST;
        state_d  = ST_EXEC;
      end
      ST_EXEC: begin
        if (dec_is_ctrl) begin
          state_d = ST_FETCH;
          unique case (dec_opcode)
            OP_JMP:  pc_d = jmp_target;
            OP_JZ:   pc_d = zf_q ? jmp_target : pc_inc;
            OP_HLT:  state_d = ST_HALT;
            default: pc_d = pc_inc;
          endcase
        end else begin
          ex_enable_c = 1'b1;
          if (ex_cnt_q == 3'd0) state_d = ST_WB;
          else                  ex_cnt_d = ex_cnt_q - 3'd1;
        end
      end
      ST_WB: begin
        zf_d    = bus.ex_zero_flag;
        pc_d    = pc_inc;
        state_d = ST_FETCH;
      end
      ST_HALT: begin
        if (start) begin
          pc_d    = RESET_PC;
          zf_d    = 1'b0;
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.imem_rd           = imem_rd_c;
  assign bus.imem_addr         = pc_q;
  assign bus.ex_enable         = ex_enable_c;
  assign bus.ex_opcode         = dec_opcode;
  assign bus.ex_am             = dec_am;
  assign bus.ex_rd             = dec_rd;
  assign bus.ex_rs1            = dec_rs1;
  assign bus.ex_rs2            = dec_rs2;
  assign bus.ex_mem_addr       = dec_mem_addr;
  assign bus.ex_instr_mem_addr = instr_pc_q;

  assign pc     = pc_q;
  assign busy   = (state_q == ST_FETCH) || (state_q == ST_DECODE) ||
                  (state_q == ST_EXEC)  || (state_q == ST_WB);
  assign halted = (state_q == ST_HALT);

endmodule

// File: tb/tb_exec_sequencer.sv
// Bench for exec_sequencer: a single-cycle and a three-cycle execute
// instance share one clock, reset and instruction memory; sel picks which
// one is driven and observed.
module tb_exec_sequencer;

  localparam logic [4:0] RPC1 = 5'd0;
  localparam logic [4:0] RPC3 = 5'd3;

  logic clk;
  logic rst;
  logic start;
  logic sel;
  logic zf_drv;
  logic start1, start3;
  logic [4:0] pc1, pc3;
  logic busy1, busy3, halted1, halted3;
  logic [15:0] mem [32];

  int n_tests = 0;
  int n_fail  = 0;

  exec_sequencer_if #(.PC_W(5), .INSTR_W(16)) b1 ();
  exec_sequencer_if #(.PC_W(5), .INSTR_W(16)) b3 ();

  exec_sequencer #(.PC_W(5), .INSTR_W(16), .EX_CYCLES(1), .RESET_PC(RPC1)) u1 (
    .clk(clk), .reset(rst), .start(start1), .bus(b1), .pc(pc1), .busy(busy1), .halted(halted1)
  );
  exec_sequencer #(.PC_W(5), .INSTR_W(16), .EX_CYCLES(3), .RESET_PC(RPC3)) u3 (
    .clk(clk), .reset(rst), .start(start3), .bus(b3), .pc(pc3), .busy(busy3), .halted(halted3)
  );

  assign start1          = start & ~sel;
  assign start3          = start & sel;
  assign b1.ex_zero_flag = zf_drv;
  assign b3.ex_zero_flag = zf_drv;

  wire        c_rd    = sel ? b3.imem_rd           : b1.imem_rd;
  wire [4:0]  c_addr  = sel ? b3.imem_addr         : b1.imem_addr;
  wire        c_en    = sel ? b3.ex_enable         : b1.ex_enable;
  wire [3:0]  c_opc   = sel ? b3.ex_opcode         : b1.ex_opcode;
  wire [9:0]  c_flds  = sel ? {b3.ex_am, b3.ex_rd, b3.ex_rs1, b3.ex_rs2}
                            : {b1.ex_am, b1.ex_rd, b1.ex_rs1, b1.ex_rs2};
  wire [4:0]  c_maddr = sel ? b3.ex_mem_addr       : b1.ex_mem_addr;
  wire [4:0]  c_iaddr = sel ? b3.ex_instr_mem_addr : b1.ex_instr_mem_addr;
  wire [4:0]  c_pc    = sel ? pc3                  : pc1;
  wire        c_busy  = sel ? busy3                : busy1;
  wire        c_halt  = sel ? halted3              : halted1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: registered read, data valid the cycle after imem_rd
  always @(posedge clk) begin
    if (b1.imem_rd) b1.imem_data <= mem[b1.imem_addr];
    if (b3.imem_rd) b3.imem_data <= mem[b3.imem_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reset (checking reset values), then start from IDLE; ends in FETCH
  task automatic start_run(input logic [4:0] rpc);
    @(negedge clk);
    rst = 1'b1; start = 1'b0; zf_drv = 1'b0;
    #1;
    chk("rst_pc", c_pc, rpc);
    chk("rst_imem_addr", c_addr, rpc);
    chk("rst_imem_rd", c_rd, 0);
    chk("rst_ex_enable", c_en, 0);
    chk("rst_busy_halted", {c_busy, c_halt}, 0);
    chk("rst_fields", {c_opc, c_flds, c_maddr, c_iaddr}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_waits_for_start", {c_busy, c_rd}, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Run one instruction starting at its FETCH cycle; checks fetch address,
  // field outputs in EXEC, ex_enable cycle count and latency to next FETCH.
  // HLT: the HALT cycle is checked and start is pulsed to restart.
  task automatic step_instr(input logic [15:0] ins, input bit zin, input logic [4:0] exp_addr,
                            input int exp_lat, input int exp_en, input bit rand_start);
    int en_cnt;
    en_cnt = 0;
    chk("fetch_rd", c_rd, 1);
    chk("fetch_addr", c_addr, exp_addr);
    chk("fetch_busy", c_busy, 1);
    mem[exp_addr] = ins;
    zf_drv = zin;
    for (int k = 0; k < exp_lat; k++) begin
      if (ins[15:12] == 4'hF && k == 3) begin
        chk("halt_flag", {c_halt, c_busy}, 2'b10);
        chk("halt_pc_held", c_pc, exp_addr);
        start = 1'b1;
      end else begin
        start = rand_start ? 1'($urandom_range(1)) : 1'b0;
      end
      if (k == 2) begin
        chk("exec_opcode", c_opc, ins[15:12]);
        chk("exec_fields", {c_flds, c_maddr}, {ins[11:2], ins[4:0]});
        chk("exec_instr_addr", c_iaddr, exp_addr);
      end
      en_cnt += int'(c_en);
      @(negedge clk);
    end
    start = 1'b0;
    chk("ex_enable_cycles", en_cnt, exp_en);
    chk("next_fetch_rd", c_rd, 1);
  endtask

  // Instruction-level reference model driving random programs
  task automatic run_random(input int n, input int exn, input logic [4:0] rpc);
    logic [4:0] mpc;
    bit         mzf;
    mpc = rpc;
    mzf = 1'b0;
    for (int i = 0; i < n; i++) begin
      int          r;
      bit          zin;
      logic [15:0] ins;
      logic [4:0]  nxt;
      int          lat, en;
      r   = int'($urandom_range(99));
      zin = 1'($urandom_range(1));
      ins = 16'($urandom);
      if      (r < 55) ins[15:12] = 4'($urandom_range(12, 1));
      else if (r < 65) ins[15:12] = 4'h0;
      else if (r < 78) ins[15:12] = 4'hD;
      else if (r < 95) ins[15:12] = 4'hE;
      else             ins[15:12] = 4'hF;
      lat = 3; en = 0; nxt = mpc + 5'd1;
      case (ins[15:12])
        4'h0: ;
        4'hD: nxt = ins[4:0];
        4'hE: if (mzf) nxt = ins[4:0];
        4'hF: begin lat = 4; nxt = rpc; mzf = 1'b0; end
        default: begin lat = 3 + exn; en = exn; mzf = zin; end
      endcase
      step_instr(ins, zin, mpc, lat, en, 1'b1);
      mpc = nxt;
    end
    chk("random_final_addr", c_addr, mpc);
  endtask

  typedef struct {
    logic [15:0] instr;
    bit          zin;
    logic [4:0]  addr;
    int          lat;
    int          en;
  } vec_t;

  vec_t tbl [12];

  initial begin
    rst = 1'b1; start = 1'b0; sel = 1'b0; zf_drv = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 16'h0000;

    tbl[0]  = '{16'h5000, 1'b0, 5'd0,  4, 1};  // ALU
    tbl[1]  = '{16'hD014, 1'b0, 5'd1,  3, 0};  // JMP 20
    tbl[2]  = '{16'h3123, 1'b1, 5'd20, 4, 1};  // ALU, zero flag 1
    tbl[3]  = '{16'hE007, 1'b0, 5'd21, 3, 0};  // JZ 7 taken
    tbl[4]  = '{16'h2000, 1'b0, 5'd7,  4, 1};  // ALU, zero flag 0
    tbl[5]  = '{16'hE007, 1'b1, 5'd8,  3, 0};  // JZ 7 not taken (live flag high)
    tbl[6]  = '{16'hD01F, 1'b0, 5'd9,  3, 0};  // JMP 31
    tbl[7]  = '{16'h0000, 1'b0, 5'd31, 3, 0};  // NOP at 31 wraps
    tbl[8]  = '{16'h4321, 1'b1, 5'd0,  4, 1};  // ALU, zero flag 1
    tbl[9]  = '{16'hF000, 1'b0, 5'd1,  4, 0};  // HLT, restart
    tbl[10] = '{16'hE003, 1'b0, 5'd0,  3, 0};  // JZ after restart: flag cleared
    tbl[11] = '{16'h7FFF, 1'b0, 5'd1,  4, 1};  // ALU

    sel = 1'b0;
    start_run(RPC1);
    for (int i = 0; i < 12; i++)
      step_instr(tbl[i].instr, tbl[i].zin, tbl[i].addr, tbl[i].lat, tbl[i].en, 1'b0);
    chk("table_end_pc", c_pc, 5'd2);

    start_run(RPC1);
    run_random(150, 1, RPC1);

    // Three-cycle execute: ALU sets zf, then reset lands mid-EXEC
    sel = 1'b1;
    start_run(RPC3);
    step_instr(16'h1000, 1'b1, RPC3, 6, 3, 1'b1);
    chk("ex3_fetch_addr", c_addr, RPC3 + 5'd1);
    mem[RPC3 + 5'd1] = 16'h2000;
    @(negedge clk);
    @(negedge clk);
    chk("mid_exec_enable", c_en, 1);
    rst = 1'b1;
    #1;
    chk("async_rst_ex_enable", c_en, 0);
    chk("async_rst_state", {c_busy, c_halt, c_rd}, 0);
    chk("async_rst_pc", c_pc, RPC3);
    @(negedge clk);
    rst = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    step_instr(16'hE00A, 1'b0, RPC3, 3, 0, 1'b0);
    step_instr(16'h6000, 1'b0, RPC3 + 5'd1, 6, 3, 1'b0);

    start_run(RPC3);
    run_random(100, 3, RPC3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
